// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table tester: walks x through 0..2**N-1, lets the DUT settle
// for HOLD cycles per vector, compares f_in against the golden table and tallies errors.
module truth_table_sweeper #(
  parameter int N = 3,
  parameter int HOLD = 2,
  parameter logic [(1<<N)-1:0] EXPECTED = 8'hE8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         f_in,
  output logic [N-1:0] x,
  output logic         sample,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic [N-1:0] first_err_vec,
  output logic [1:0]   dbg_state
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] HOLD_RELOAD = CW'(HOLD - 1);
  localparam logic [N-1:0]  X_LAST = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_x;
  logic [CW-1:0] r_cnt;
  logic [N:0]    r_err;
  logic [N-1:0]  r_first;
  logic          w_mismatch;

  assign w_mismatch = (f_in != EXPECTED[r_x]);

  // start is a level request, only looked at in IDLE or DONE; it has no
  // handshake back, so holding it high during a sweep has no effect until DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_cnt   <= '0;
      r_err   <= '0;
      r_first <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_x     <= '0;
            r_cnt   <= HOLD_RELOAD;
            r_err   <= '0;
            r_first <= '0;
            r_state <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_cnt == '0) begin
            r_state <= CHECK;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        CHECK: begin
          if (w_mismatch) begin
            r_err <= r_err + (N+1)'(1);
            if (r_err == '0) begin
              r_first <= r_x;
            end
          end
          // x stops at the last vector so it stays visible in DONE
          if (r_x == X_LAST) begin
            r_state <= DONE;
          end else begin
            r_x     <= r_x + N'(1);
            r_cnt   <= HOLD_RELOAD;
            r_state <= SETTLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign x             = r_x;
  assign sample        = (r_state == CHECK);
  assign busy          = (r_state == SETTLE) || (r_state == CHECK);
  assign done          = (r_state == DONE);
  assign pass          = (r_state == DONE) && (r_err == '0);
  assign err_count     = r_err;
  assign first_err_vec = r_first;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: a 3-input majority instance and a
// 4-input XOR instance, each driven by a small combinational model DUT.
module tb_truth_table_sweeper;

  logic clk;
  logic rst;
  logic start;
  logic sel;
  logic mode;

  logic       start3, start4;
  logic       f3, f4;
  logic [2:0] x3, fe3;
  logic [3:0] x4, fe4;
  logic       sample3, busy3, done3, pass3;
  logic       sample4, busy4, done4, pass4;
  logic [3:0] err3;
  logic [4:0] err4;
  logic [1:0] st3, st4;

  int n_checks;
  int n_fail;

  logic [31:0] cur_x, cur_err, cur_first, cur_state;
  logic        cur_sample, cur_busy, cur_done, cur_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign start3 = start & ~sel;
  assign start4 = start & sel;

  // mode 0: correct DUT; mode 1: faulty DUT (stuck-at-0 / inverted parity)
  assign f3 = mode ? 1'b0 : ((x3[2] & x3[1]) | (x3[2] & x3[0]) | (x3[1] & x3[0]));
  assign f4 = mode ? ~^x4 : ^x4;

  truth_table_sweeper #(.N(3), .HOLD(2), .EXPECTED(8'hE8)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .f_in(f3), .x(x3),
    .sample(sample3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .first_err_vec(fe3), .dbg_state(st3)
  );

  truth_table_sweeper #(.N(4), .HOLD(1), .EXPECTED(16'h6996)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .f_in(f4), .x(x4),
    .sample(sample4), .busy(busy4), .done(done4), .pass(pass4),
    .err_count(err4), .first_err_vec(fe4), .dbg_state(st4)
  );

  always_comb begin
    cur_x      = sel ? 32'(x4)   : 32'(x3);
    cur_err    = sel ? 32'(err4) : 32'(err3);
    cur_first  = sel ? 32'(fe4)  : 32'(fe3);
    cur_state  = sel ? 32'(st4)  : 32'(st3);
    cur_sample = sel ? sample4 : sample3;
    cur_busy   = sel ? busy4   : busy3;
    cur_done   = sel ? done4   : done3;
    cur_pass   = sel ? pass4   : pass3;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Pulse (or hold) start, then follow the sweep cycle by cycle until done.
  task automatic run_sweep(input string tag, input int hold, input int nv, input bit keep_start,
                           output int cycles);
    int samples;
    int seq_err;
    int cyc;
    samples = 0;
    seq_err = 0;
    cyc = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!keep_start) start = 1'b0;
    while (!cur_done && cyc < 200) begin
      if (cur_x != 32'(cyc / (hold + 1))) seq_err++;
      if (cur_sample != ((cyc % (hold + 1)) == hold)) seq_err++;
      if (!cur_busy) seq_err++;
      if (cur_sample) samples++;
      @(posedge clk);
      #1;
      cyc++;
    end
    cycles = cyc;
    check({tag, "_done_latency"}, 32'(cyc), 32'(nv * (hold + 1)));
    check({tag, "_sample_count"}, 32'(samples), 32'(nv));
    check({tag, "_x_sample_seq_errs"}, 32'(seq_err), 32'd0);
    check({tag, "_x_final"}, cur_x, 32'(nv - 1));
    check({tag, "_busy_in_done"}, 32'(cur_busy), 32'd0);
  endtask

  initial begin
    int cyc;
    int waited;
    n_checks = 0;
    n_fail = 0;
    rst = 1'b0;
    start = 1'b0;
    sel = 1'b0;
    mode = 1'b0;

    do_reset();
    check("rst_x", cur_x, 32'd0);
    check("rst_sample", 32'(cur_sample), 32'd0);
    check("rst_busy", 32'(cur_busy), 32'd0);
    check("rst_done", 32'(cur_done), 32'd0);
    check("rst_pass", 32'(cur_pass), 32'd0);
    check("rst_err", cur_err, 32'd0);
    check("rst_first", cur_first, 32'd0);
    check("rst_state", cur_state, 32'd0);

    repeat (5) @(posedge clk);
    #1;
    check("idle_hold_state", cur_state, 32'd0);

    // golden majority DUT
    run_sweep("gold", 2, 8, 1'b0, cyc);
    check("gold_pass", 32'(cur_pass), 32'd1);
    check("gold_err", cur_err, 32'd0);
    check("gold_first", cur_first, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("gold_done_holds", 32'(cur_done), 32'd1);

    // stuck-at-0 DUT, restarted straight from DONE
    mode = 1'b1;
    run_sweep("stuck0", 2, 8, 1'b0, cyc);
    check("stuck0_err", cur_err, 32'd4);
    check("stuck0_first", cur_first, 32'd3);
    check("stuck0_pass", 32'(cur_pass), 32'd0);

    // reset in the middle of a sweep while x == 5
    mode = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waited = 0;
    while (cur_x != 32'd5 && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("midrst_reached_x5", cur_x, 32'd5);
    do_reset();
    check("midrst_x", cur_x, 32'd0);
    check("midrst_busy", 32'(cur_busy), 32'd0);
    check("midrst_sample", 32'(cur_sample), 32'd0);
    check("midrst_err", cur_err, 32'd0);
    check("midrst_state", cur_state, 32'd0);
    run_sweep("after_rst", 2, 8, 1'b0, cyc);
    check("after_rst_pass", 32'(cur_pass), 32'd1);

    // start held high: one sweep only, then restart from DONE clears results
    mode = 1'b1;
    run_sweep("held", 2, 8, 1'b1, cyc);
    check("held_err", cur_err, 32'd4);
    @(posedge clk);
    #1;
    check("held_restart_err", cur_err, 32'd0);
    check("held_restart_busy", 32'(cur_busy), 32'd1);
    check("held_restart_x", cur_x, 32'd0);
    start = 1'b0;
    do_reset();

    // parametric N=4, HOLD=1, XOR4
    sel = 1'b1;
    mode = 1'b0;
    run_sweep("xor4", 1, 16, 1'b0, cyc);
    check("xor4_pass", 32'(cur_pass), 32'd1);
    check("xor4_err", cur_err, 32'd0);
    mode = 1'b1;
    run_sweep("xnor4", 1, 16, 1'b0, cyc);
    check("xnor4_err", cur_err, 32'd16);
    check("xnor4_first", cur_first, 32'd0);
    check("xnor4_pass", 32'(cur_pass), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
